// File: rtl/core_lsu.sv
// core_lsu: single-transaction load/store unit between core_alu and a req/ack data bus.
// Decodes the one-hot access flags, rejects illegal/misaligned requests and extends load data.
module core_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        start,
    input  logic        i_lb,
    input  logic        i_lh,
    input  logic        i_lw,
    input  logic        i_lbu,
    input  logic        i_lhu,
    input  logic        i_sb,
    input  logic        i_sh,
    input  logic        i_sw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [1:0]  size_reg;      // 0 byte, 1 halfword, 2 word
    logic        unsigned_reg;
    logic [1:0]  lane_reg;

    logic [7:0]  flags;
    logic        multi_flag;
    logic        misaligned;
    logic        is_store;
    logic        is_unsigned;
    logic [1:0]  size_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_next;
    logic [8:0]  cnt_next;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte [4];

    assign flags       = {i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw};
    assign multi_flag  = (flags & (flags - 8'd1)) != 8'd0;
    assign is_store    = i_sb | i_sh | i_sw;
    assign is_unsigned = i_lbu | i_lhu;
    assign size_next   = (i_lw | i_sw) ? 2'd2 : (i_lh | i_lhu | i_sh) ? 2'd1 : 2'd0;
    assign misaligned  = ((size_next == 2'd1) && addr[0]) ||
                         ((size_next == 2'd2) && (addr[1:0] != 2'b00));
    assign cnt_next    = {1'b0, cnt_reg} + 9'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign rd_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (size_next)
            2'd0: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'd1: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!is_store) begin
            wdata_next = 32'd0;
        end
    end

    // Lane and extension come from what was latched at start, not the live inputs.
    always_comb begin
        load_next = mem_rdata;
        case (size_reg)
            2'd0: load_next = {{24{rd_byte[lane_reg][7] & ~unsigned_reg}}, rd_byte[lane_reg]};
            2'd1: load_next = {{16{rd_half[15] & ~unsigned_reg}}, rd_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            size_reg     <= 2'd0;
            unsigned_reg <= 1'b0;
            lane_reg     <= 2'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            load_data    <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && (flags != 8'd0)) begin
                        if (multi_flag || misaligned) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state_reg    <= ACCESS;
                            cnt_reg      <= 8'd0;
                            size_reg     <= size_next;
                            unsigned_reg <= is_unsigned;
                            lane_reg     <= addr[1:0];
                            mem_req      <= 1'b1;
                            busy         <= 1'b1;
                            mem_we       <= is_store;
                            mem_addr     <= {addr[31:2], 2'b00};
                            mem_be       <= be_next;
                            mem_wdata    <= wdata_next;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final permitted cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state_reg <= IDLE;
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        if (!mem_we) begin
                            load_data <= load_next;
                        end
                    end else if (cnt_next == TIMEOUT_CNT) begin
                        state_reg <= IDLE;
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_next[7:0];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_lsu.sv
// Directed plus randomized bench for core_lsu against a byte-level reference model.
module tb_core_lsu;
    localparam int TMO = 4;

    // Flag vector bit order: {lb, lh, lw, lbu, lhu, sb, sh, sw}
    localparam logic [7:0] F_LB = 8'h80, F_LH = 8'h40, F_LW = 8'h20, F_LBU = 8'h10;
    localparam logic [7:0] F_LHU = 8'h08, F_SB = 8'h04, F_SH = 8'h02, F_SW = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  fl = 8'd0;
    logic        i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] load_data;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_load = 32'd0;

    assign {i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw} = fl;

    core_lsu #(.TIMEOUT(TMO)) dut (
        .rst_n(rst_n), .clk(clk), .start(start),
        .i_lb(i_lb), .i_lh(i_lh), .i_lw(i_lw), .i_lbu(i_lbu), .i_lhu(i_lhu),
        .i_sb(i_sb), .i_sh(i_sh), .i_sw(i_sw),
        .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .load_data(load_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Reference model: access width in bytes, legality and expected bus/load values.
    function automatic int nbytes(input logic [7:0] f);
        if ((f & (F_LB | F_LBU | F_SB)) != 0) return 1;
        if ((f & (F_LH | F_LHU | F_SH)) != 0) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input int n, input logic [31:0] a);
        logic [31:0] m;
        m = ((32'd1 << n) - 32'd1) << (a % 32'd4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] f, input int n, input logic [31:0] wd);
        logic [31:0] v;
        v = 32'd0;
        if ((f & (F_SB | F_SH | F_SW)) != 0)
            for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] f, input int n, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v, mask;
        v    = rd >> (8 * (a % 32'd4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (((f & (F_LB | F_LH)) != 0) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One access; delay = number of req cycles before ack (>= TMO means never ack).
    task automatic access(input logic [7:0] f, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int delay, input bit poke);
        int  n;
        bit  legal;
        bit  is_store;
        n        = nbytes(f);
        legal    = ($countones(f) == 1) && ((a % n) == 0);
        is_store = (f & (F_SB | F_SH | F_SW)) != 0;
        $display("[TB] access flags=%h addr=%h wdata=%h rdata=%h delay=%0d", f, a, wd, rd, delay);
        check("idle_before_start", 32'(busy), 32'd0);
        fl = f; addr = a; wdata = wd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fl = 8'd0;
        if (f == 8'd0) begin
            check("noflag_busy", 32'(busy), 32'd0);
            check("noflag_req", 32'(mem_req), 32'd0);
            check("noflag_done", 32'(done), 32'd0);
            return;
        end
        if (!legal) begin
            check("illegal_req", 32'(mem_req), 32'd0);
            check("illegal_busy", 32'(busy), 32'd0);
            check("illegal_done", 32'(done), 32'd1);
            check("illegal_err", 32'(err), 32'd1);
            check("illegal_load_kept", load_data, exp_load);
            return;
        end
        check("start_done", 32'(done), 32'd0);
        for (int c = 0; c < TMO + 2; c++) begin
            check("req_high", 32'(mem_req), 32'd1);
            check("busy_high", 32'(busy), 32'd1);
            check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("mem_be", 32'(mem_be), 32'(model_be(n, a)));
            check("mem_we", 32'(mem_we), 32'(is_store));
            check("mem_wdata", mem_wdata, model_wdata(f, n, wd));
            if (poke) begin
                start = 1'b1; fl = F_SW; addr = 32'h0000_0040;
            end
            if (c == delay) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; start = 1'b0; fl = 8'd0;
            if (c == delay) begin
                if (!is_store) exp_load = model_load(f, n, a, rd);
                check("ack_done", 32'(done), 32'd1);
                check("ack_err", 32'(err), 32'd0);
                check("ack_req_low", 32'(mem_req), 32'd0);
                check("ack_busy_low", 32'(busy), 32'd0);
                check("load_data", load_data, exp_load);
                return;
            end
            if (c + 1 == TMO) begin
                check("tmo_done", 32'(done), 32'd1);
                check("tmo_err", 32'(err), 32'd1);
                check("tmo_req_low", 32'(mem_req), 32'd0);
                check("tmo_load_kept", load_data, exp_load);
                return;
            end
            check("wait_done_low", 32'(done), 32'd0);
        end
        tests++;
        fails++;
        $error("FAIL access_bound: observed no completion expected done within %0d cycles", TMO);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        logic [7:0]  f;
        logic [31:0] a;
        int          r, x;

        // Reset state
        #12;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_load", load_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LW with ack two cycles into the request
        access(F_LW, 32'h104, 32'd0, 32'hDEAD_BEEF, 2, 1'b0);
        check("lw_value", load_data, 32'hDEAD_BEEF);
        idle_cycle();

        // Lane select and extension
        access(F_LB, 32'h103, 32'd0, 32'h80FF_0000, 0, 1'b0);
        check("lb_value", load_data, 32'hFFFF_FF80);
        access(F_LBU, 32'h103, 32'd0, 32'h80FF_0000, 1, 1'b0);
        check("lbu_value", load_data, 32'h0000_0080);
        access(F_LH, 32'h102, 32'd0, 32'h80FF_0000, 0, 1'b0);
        check("lh_value", load_data, 32'hFFFF_80FF);
        access(F_LHU, 32'h102, 32'd0, 32'h80FF_0000, 0, 1'b0);
        check("lhu_value", load_data, 32'h0000_80FF);

        // Stores leave load_data alone
        access(F_SB, 32'h7, 32'h1234_56AB, 32'h5555_5555, 0, 1'b0);
        check("sb_load_kept", load_data, 32'h0000_80FF);
        access(F_SH, 32'h6, 32'h0000_BEEF, 32'h5555_5555, 1, 1'b0);
        check("sh_load_kept", load_data, 32'h0000_80FF);

        // Misaligned, multi-flag and no-flag requests
        access(F_SW, 32'h3, 32'h1, 32'd0, 0, 1'b0);
        access(F_LH, 32'h1, 32'd0, 32'd0, 0, 1'b0);
        access(F_LW | F_SW, 32'h100, 32'd0, 32'd0, 0, 1'b0);
        access(8'd0, 32'h100, 32'd0, 32'd0, 0, 1'b0);
        idle_cycle();

        // Timeout and ack in the last permitted cycle
        access(F_LW, 32'h200, 32'd0, 32'd0, TMO, 1'b0);
        access(F_LW, 32'h204, 32'd0, 32'hCAFE_F00D, TMO - 1, 1'b0);
        check("late_ack_value", load_data, 32'hCAFE_F00D);

        // start during ACCESS is ignored and not queued
        access(F_LBU, 32'h301, 32'd0, 32'h0000_A500, 2, 1'b1);
        idle_cycle();

        // Back-to-back LW then SW: second start issued in the done cycle
        access(F_LW, 32'h400, 32'd0, 32'h0102_0304, 0, 1'b0);
        access(F_SW, 32'h404, 32'hA5A5_5A5A, 32'd0, 0, 1'b0);

        // Asynchronous reset mid-transaction
        fl = F_LW; addr = 32'h500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fl = 8'd0;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] async reset during access");
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_be", 32'(mem_be), 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_load", load_data, 32'd0);
        exp_load = 32'd0;
        #2 rst_n = 1'b1;
        idle_cycle();

        // Randomized accesses against the model
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                f = 8'd1 << r;
            end else if (r == 8) begin
                x = $urandom_range(0, 7);
                f = (8'd1 << x) | (8'd1 << ((x + 1 + $urandom_range(0, 6)) % 8));
            end else begin
                f = 8'd0;
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(f)) - 32'd1);
            access(f, a, $urandom, $urandom, $urandom_range(0, TMO), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
